shifter_iterative: RTL

Multicycle shift unit for the MIPS datapath. It sits directly downstream of the shift-amount mux and consumes its 5-bit output. It shifts or rotates a 32-bit operand by that amount, one bit position per clock cycle. The control unit triggers it with `start`, waits on `done`, and then writes `data_out` back to the register file.

---
 rtl/shifter_iterative.sv | 107 ++++++++++
 1 files changed

// File: rtl/shifter_iterative.sv
// Multicycle 32-bit shift/rotate unit: moves the operand one bit position per clock,
// with a start/busy/done handshake for the control unit.
module shifter_iterative (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  shift_op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shift_amt,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_sr_nxt;
    logic [AMT_W-1:0]  r_cnt;
    logic [AMT_W-1:0]  w_cnt_nxt;
    logic [OP_W-1:0]   r_op;
    logic [OP_W-1:0]   w_op_nxt;
    logic              r_busy;
    logic              r_done;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_sr_nxt  = data_in;
                    w_op_nxt  = shift_op;
                    w_cnt_nxt = shift_amt;
                    // Zero amount or pass-through ops complete without shifting
                    if ((shift_amt == AMT_W'(0)) || (shift_op > OP_ROR)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end else if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                case (r_op)
                    OP_SLL:  w_sr_nxt = {r_sr[DATA_W-2:0], 1'b0};
                    OP_SRL:  w_sr_nxt = {1'b0, r_sr[DATA_W-1:1]};
                    OP_SRA:  w_sr_nxt = {r_sr[DATA_W-1], r_sr[DATA_W-1:1]};
                    OP_ROL:  w_sr_nxt = {r_sr[DATA_W-2:0], r_sr[DATA_W-1]};
                    OP_ROR:  w_sr_nxt = {r_sr[0], r_sr[DATA_W-1:1]};
                    default: w_sr_nxt = r_sr;
                endcase
                w_cnt_nxt = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data_out = r_sr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
